// File: rtl/keypad_scan_if.sv
// Keypad-side signal bundle for keypad_scan: row sense, column drive and the
// keycode/keyenbl pair handed to the lock.
interface keypad_scan_if;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] keycode;
  logic       keyenbl;

  modport master (input row, output col, keycode, keyenbl);
  modport slave  (output row, input col, keycode, keyenbl);
endinterface

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner with press/release debounce and a one-cycle key strobe.
// Define KEYPAD_REPEAT_EN to add auto-repeat while a key stays held.
module keypad_scan #(
  parameter logic [15:0] SCAN_DIV = 16'd1000,
  parameter logic [7:0]  DEB_CNT  = 8'd4,
  parameter logic [7:0]  REP_DLY  = 8'd32,
  parameter logic [7:0]  REP_PER  = 8'd8
) (
  input logic         ck,
  input logic         resetn,
  keypad_scan_if.master kp
);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

  state_t      state, state_next;
  logic [15:0] presc;
  logic        tick;
  logic [3:0]  rs_meta, rs;
  logic [1:0]  cidx, cidx_next;
  logic [3:0]  cand, cand_next;
  logic [7:0]  deb, deb_next;
  logic [3:0]  keycode_q;
  logic        keyenbl_q;
  logic        accept, strobe, valid;
  logic [1:0]  ridx;

  function automatic logic [3:0] keymap(input logic [3:0] rc);
    case (rc)
      4'd0:  keymap = 4'h1;  4'd1:  keymap = 4'h2;  4'd2:  keymap = 4'h3;  4'd3:  keymap = 4'hA;
      4'd4:  keymap = 4'h4;  4'd5:  keymap = 4'h5;  4'd6:  keymap = 4'h6;  4'd7:  keymap = 4'hB;
      4'd8:  keymap = 4'h7;  4'd9:  keymap = 4'h8;  4'd10: keymap = 4'h9;  4'd11: keymap = 4'hC;
      4'd12: keymap = 4'hE;  4'd13: keymap = 4'h0;  4'd14: keymap = 4'hF;  default: keymap = 4'hD;
    endcase
  endfunction

  always_ff @(posedge ck or negedge resetn) begin
    if (!resetn) begin
      rs_meta <= 4'hf;
      rs      <= 4'hf;
      presc   <= 16'd0;
    end else begin
      rs_meta <= kp.row;
      rs      <= rs_meta;
      presc   <= tick ? 16'd0 : presc + 16'd1;
    end
  end

  assign tick = (presc == SCAN_DIV - 16'd1);

  // A sample is a key only when exactly one row is pulled low.
  always_comb begin
    valid = 1'b1;
    ridx  = 2'd0;
    case (rs)
      4'b1110: ridx = 2'd0;
      4'b1101: ridx = 2'd1;
      4'b1011: ridx = 2'd2;
      4'b0111: ridx = 2'd3;
      default: valid = 1'b0;
    endcase
  end

  always_ff @(posedge ck or negedge resetn) begin
    if (!resetn) begin
      state <= SCAN;
      cidx  <= 2'd0;
      cand  <= 4'd0;
      deb   <= 8'd0;
    end else begin
      state <= state_next;
      cidx  <= cidx_next;
      cand  <= cand_next;
      deb   <= deb_next;
    end
  end

  always_comb begin
    state_next = state;
    cidx_next  = cidx;
    cand_next  = cand;
    deb_next   = deb;
    accept     = 1'b0;
    if (tick) begin
      case (state)
        SCAN: begin
          if (valid) begin
            cand_next = {ridx, cidx};
            deb_next  = 8'd1;
            if (DEB_CNT == 8'd1) begin
              accept     = 1'b1;
              state_next = HELD;
            end else begin
              state_next = DEBOUNCE;
            end
          end else begin
            cidx_next = cidx + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (valid && ridx == cand[3:2]) begin
            deb_next = deb + 8'd1;
            if (deb + 8'd1 == DEB_CNT) begin
              accept     = 1'b1;
              state_next = HELD;
            end
          end else begin
            state_next = SCAN;
            cidx_next  = cidx + 2'd1;
          end
        end
        HELD: begin
          if (rs == 4'hf) begin
            deb_next = 8'd1;
            if (DEB_CNT == 8'd1) begin
              state_next = SCAN;
              cidx_next  = cidx + 2'd1;
            end else begin
              state_next = RELEASE;
            end
          end
        end
        default: begin
          // Any low row while releasing is treated as release bounce.
          if (rs == 4'hf) begin
            deb_next = deb + 8'd1;
            if (deb + 8'd1 == DEB_CNT) begin
              state_next = SCAN;
              cidx_next  = cidx + 2'd1;
            end
          end else begin
            state_next = HELD;
          end
        end
      endcase
    end
  end

`ifdef KEYPAD_REPEAT_EN
  logic [7:0] rep_cnt;
  logic       rep_first, rep_fire;

  // First repeat waits REP_DLY ticks, later ones REP_PER ticks.
  assign rep_fire = tick && state == HELD && state_next == HELD &&
                    (rep_cnt + 8'd1 == (rep_first ? REP_DLY : REP_PER));

  always_ff @(posedge ck or negedge resetn) begin
    if (!resetn) begin
      rep_cnt   <= 8'd0;
      rep_first <= 1'b1;
    end else if (state != HELD) begin
      rep_cnt   <= 8'd0;
      rep_first <= 1'b1;
    end else if (rep_fire) begin
      rep_cnt   <= 8'd0;
      rep_first <= 1'b0;
    end else if (tick) begin
      rep_cnt <= rep_cnt + 8'd1;
    end
  end

  assign strobe = accept | rep_fire;
`else
  assign strobe = accept;
`endif

  always_ff @(posedge ck or negedge resetn) begin
    if (!resetn) begin
      keycode_q <= 4'h0;
      keyenbl_q <= 1'b0;
    end else begin
      keyenbl_q <= strobe;
      if (accept) keycode_q <= keymap(cand_next);
    end
  end

  assign kp.col     = ~(4'b0001 << cidx);
  assign kp.keycode = keycode_q;
  assign kp.keyenbl = keyenbl_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Scoreboard bench for keypad_scan: a behavioural keypad matrix drives rows from
// the column drive, expected keycodes are queued on press and popped on each strobe.
module tb_keypad_scan;
  logic        ck = 1'b0;
  logic        resetn;
  logic [15:0] pressed;
  logic [3:0]  row_drive;
  logic [3:0]  exp_q[$];
  logic [3:0]  mon_exp;
  int          n_checks = 0;
  int          n_pass = 0;
  int          n_strobe = 0;
  int          base;

  localparam logic [15:0] KEY_NONE = 16'h0000;
  localparam logic [15:0] KEY_9    = 16'h0400;
  localparam logic [15:0] KEY_5    = 16'h0020;
  localparam logic [15:0] KEY_E    = 16'h1000;
  localparam logic [15:0] KEY_1_4  = 16'h0011;
  localparam logic [15:0] KEY_C    = 16'h0800;
  localparam logic [15:0] KEY_0    = 16'h2000;

  keypad_scan_if kp();

  keypad_scan #(
    .SCAN_DIV(16'd4),
    .DEB_CNT (8'd3),
    .REP_DLY (8'd8),
    .REP_PER (8'd4)
  ) dut (
    .ck    (ck),
    .resetn(resetn),
    .kp    (kp)
  );

  always #5 ck = ~ck;

  // Key at row r / column c shorts row r low while column c is driven low.
  always_comb begin
    row_drive = 4'hf;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !kp.col[c]) row_drive[r] = 1'b0;
  end
  assign kp.row = row_drive;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp)
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    else
      n_pass++;
  endtask

  task automatic applyStimulus(input logic [15:0] keys, input int cycles);
    @(negedge ck);
    pressed = keys;
    repeat (cycles) @(negedge ck);
  endtask

  task automatic waitStrobe(input string tag, input int since, input int bound);
    for (int i = 0; i < bound && n_strobe == since; i++) @(negedge ck);
    checkOutput(tag, 32'(n_strobe > since), 32'd1);
  endtask

  task automatic checkColCycle(input string tag);
    logic [3:0] prev;
    int         steps;
    prev  = kp.col;
    steps = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge ck);
      if (kp.col !== prev) begin
        steps++;
        checkOutput({tag, " rotate"}, 32'(kp.col), 32'({prev[2:0], prev[3]}));
      end
      prev = kp.col;
    end
    checkOutput({tag, " steps"}, 32'(steps), 32'd8);
  endtask

  always @(negedge ck) begin
    if (resetn && kp.keyenbl) begin
      n_strobe++;
      if (exp_q.size() == 0) begin
        checkOutput("unexpected keyenbl", 32'd1, 32'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        checkOutput("keycode", 32'(kp.keycode), 32'(mon_exp));
      end
    end
  end

  initial begin
    pressed = KEY_NONE;
    resetn  = 1'b0;
    repeat (3) @(negedge ck);
    checkOutput("reset col", 32'(kp.col), 32'h0000000e);
    checkOutput("reset keycode", 32'(kp.keycode), 32'd0);
    checkOutput("reset keyenbl", 32'(kp.keyenbl), 32'd0);
    resetn = 1'b1;

    $display("[TB] idle column scan");
    applyStimulus(KEY_NONE, 2);
    checkColCycle("idle col");

    $display("[TB] hold key 9");
    base = n_strobe;
    exp_q.push_back(4'h9);
    applyStimulus(KEY_9, 1);
    waitStrobe("strobe 9", base, 200);
    applyStimulus(KEY_9, 200);

    $display("[TB] bouncy release then key E");
    applyStimulus(KEY_NONE, 4);
    applyStimulus(KEY_9, 4);
    applyStimulus(KEY_NONE, 4);
    applyStimulus(KEY_9, 4);
    applyStimulus(KEY_NONE, 40);
    base = n_strobe;
    exp_q.push_back(4'hE);
    applyStimulus(KEY_E, 1);
    waitStrobe("strobe E", base, 200);
    applyStimulus(KEY_E, 20);
    applyStimulus(KEY_NONE, 40);

    $display("[TB] bouncy press of key 5");
    base = n_strobe;
    exp_q.push_back(4'h5);
    applyStimulus(KEY_5, 4);
    applyStimulus(KEY_NONE, 4);
    applyStimulus(KEY_5, 4);
    applyStimulus(KEY_NONE, 4);
    applyStimulus(KEY_5, 1);
    waitStrobe("strobe 5", base, 200);
    applyStimulus(KEY_5, 20);
    applyStimulus(KEY_NONE, 40);

    $display("[TB] two rows on one column");
    applyStimulus(KEY_1_4, 4);
    checkColCycle("multirow col");
    applyStimulus(KEY_1_4, 60);
    applyStimulus(KEY_NONE, 20);

    $display("[TB] reset during debounce of C");
    for (int i = 0; i < 64 && kp.col !== 4'b1110; i++) @(negedge ck);
    pressed = KEY_C;
    for (int i = 0; i < 64 && kp.col !== 4'b0111; i++) @(negedge ck);
    repeat (6) @(posedge ck);
    #1;
    checkOutput("debounce col frozen", 32'(kp.col), 32'h00000007);
    resetn = 1'b0;
    #1;
    checkOutput("midreset col", 32'(kp.col), 32'h0000000e);
    checkOutput("midreset keycode", 32'(kp.keycode), 32'd0);
    checkOutput("midreset keyenbl", 32'(kp.keyenbl), 32'd0);
    pressed = KEY_NONE;
    repeat (3) @(negedge ck);
    resetn = 1'b1;
    applyStimulus(KEY_NONE, 40);

    $display("[TB] long hold of key 0");
    base = n_strobe;
    exp_q.push_back(4'h0);
`ifdef KEYPAD_REPEAT_EN
    for (int i = 0; i < 5; i++) exp_q.push_back(4'h0);
`endif
    applyStimulus(KEY_0, 1);
    waitStrobe("strobe 0", base, 200);
    applyStimulus(KEY_0, 98);
    applyStimulus(KEY_NONE, 60);

    checkOutput("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
